regfile_ctrl: RTL and testbench
===============================

Name: regfile_ctrl

Overview:
- Sequencer and arbiter in front of the 2-read/1-write register file.
- Shares the register file between two requesters with round-robin arbitration and a one-slot request/grant handshake.
- Tags the 1-cycle-latency read data back to the granted requester.
- The register file has no reset, so this block clears it by sweeping zeros through every writable register after reset or on demand.
- Suppresses writes to register 0 so it stays hardwired to zero.

Parameters:
- N, 32, data width of each register.
- M, 2, register address width (2^M registers); M >= 1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- clr  in  1  request a clear sweep (sampled at posedge)
- busy  out  1  high while sweeping; requesters are not served
- req_valid  in  2  per-requester request valid (bit i = requester i)
- req_ready  out  2  per-requester grant; a transfer occurs when valid&ready
- req_ra  in  2*M  read address A, requester i at [i*M +: M]
- req_rb  in  2*M  read address B
- req_we  in  2  write enable
- req_wa  in  2*M  write address
- req_wd  in  2*N  write data
- req_wmask  in  2*N  write bit-mask (1 = overwrite)
- rf_r1, rf_r2  out  M  register file read addresses
- rf_w1  out  M  register file write address
- rf_mask  out  N  register file write mask
- rf_wf  out  1  register file write flag
- rf_w  out  N  register file write data
- rf_v1, rf_v2  in  N  register file read data (registered inside the register file)
- rsp_valid  out  1  read response valid
- rsp_id  out  1  requester that owns the response
- rsp_v1, rsp_v2  out  N  response data (pass-through of rf_v1/rf_v2)

Behaviour:
- State machine, states ST_CLEAR and ST_RUN.
- Reset: state=ST_CLEAR, idx=1, prio=0, rsp_valid=0, rsp_id=0.
  - Reset applies at any time, including mid-sweep or mid-transfer; it restarts the sweep.
- ST_CLEAR:
  - busy=1, req_ready=0.
  - Drives rf_wf=1, rf_w1=idx, rf_w=0, rf_mask=all ones, rf_r1=rf_r2=0.
  - idx increments each cycle.
  - When idx==2^M-1, the state moves to ST_RUN after that cycle, so the sweep lasts 2^M-1 cycles (3 at M=2).
  - clr during ST_CLEAR resets idx to 1 (restarts the sweep).
- ST_RUN:
  - busy=0.
  - Grant is combinational:
    - if only one req_valid is set, that requester is granted;
    - if both are set, requester prio is granted;
    - if none, no grant.
  - req_ready = grant one-hot; at most one bit is set.
  - On grant g:
    - rf_r1=req_ra[g], rf_r2=req_rb[g], rf_w1=req_wa[g], rf_w=req_wd[g], rf_mask=req_wmask[g];
    - rf_wf = req_we[g] && req_wa[g]!=0;
    - prio <= ~g.
  - With no grant: rf_wf=0, all rf address/data outputs 0, prio unchanged.
  - clr in ST_RUN: the current cycle still grants normally; state=ST_CLEAR, idx=1 next cycle.
- Response path:
  - rsp_valid <= (grant made this cycle); rsp_id <= g.
  - The response appears the cycle after the grant, aligned with rf_v1/rf_v2.
  - Every grant produces a response, including write-only requests and writes to register 0.
  - There is no response backpressure; requesters must accept.
  - A grant in the last ST_RUN cycle before a sweep still returns its response.
- Read and write of the same register in one granted request: the read returns the old value; the next read returns the new value.
- The mask merge (old&~mask | new&mask) is performed by the register file. A mask of 0 is issued unchanged and has no effect.
- Write data/address to register 0 are driven, but rf_wf=0.

Decomposition:
- Package regfile_ctrl_pkg:
  - state enum {ST_CLEAR, ST_RUN};
  - NREQ=2.
- Sub-module rr_arbiter2:
  - inputs: clk, rst, req[1:0], en;
  - outputs: gnt[1:0] one-hot, gnt_id;
  - holds the prio register; priority flips only on a grant while en=1.

Test Plan (N=32, M=2, register file instantiated):
- Reset sweep: release rst -> busy=1 for 3 cycles with rf_wf=1, rf_w1=1,2,3, rf_w=0, rf_mask=FFFFFFFF; then busy=0 and req_ready follows req_valid.
- Masked write then read:
  - req0 we=1, wa=2, wd=DEADBEEF, wmask=0000FFFF, granted;
  - next request req0 ra=2 -> one cycle later rsp_valid=1, rsp_id=0, rsp_v1=0000BEEF.
- Contention: both req_valid held for 4 cycles from prio=0 -> req_ready = 01,10,01,10; rsp_id = 0,1,0,1 one cycle later.
- Register-0 protection:
  - req1 we=1, wa=0, wd=5 -> rf_wf=0, rsp_valid=1, rsp_id=1;
  - subsequent read ra=0 -> rsp_v1=0.
- Same-cycle RAW: reg3=0; req0 ra=3, we=1, wa=3, wd=7 -> rsp_v1=0; a following read ra=3 -> rsp_v1=7.
- clr mid-traffic:
  - reg1=AA; clr pulsed alongside a granted read of reg1 -> that response is still returned (AA);
  - then busy=1 for 3 cycles; a read ra=1 after busy falls -> rsp_v1=0;
  - clr pulsed again mid-sweep -> sweep restarts at idx=1.

Source files
------------

// File: rtl/regfile_ctrl_pkg.sv
// Shared types and constants for the register-file sequencer/arbiter.
//   state_t : controller state (sweeping zeros vs. serving requesters)
//   NREQ    : number of requesters sharing the register file
package regfile_ctrl_pkg;

    localparam int unsigned NREQ = 2;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_ctrl_if.sv
// Requester-side bus of regfile_ctrl: per-requester request fields packed
// requester i at [i*W +: W], a per-requester grant and a shared tagged response.
//   master : the requesters (drive req_*, receive req_ready and rsp_*)
//   slave  : the controller
interface regfile_ctrl_if #(
    parameter int unsigned N = 32,
    parameter int unsigned M = 2
);
    import regfile_ctrl_pkg::*;

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*M-1:0] req_ra;
    logic [NREQ*M-1:0] req_rb;
    logic [NREQ-1:0]   req_we;
    logic [NREQ*M-1:0] req_wa;
    logic [NREQ*N-1:0] req_wd;
    logic [NREQ*N-1:0] req_wmask;
    logic              rsp_valid;
    logic              rsp_id;
    logic [N-1:0]      rsp_v1;
    logic [N-1:0]      rsp_v2;

    modport master (
        output req_valid, req_ra, req_rb, req_we, req_wa, req_wd, req_wmask,
        input  req_ready, rsp_valid, rsp_id, rsp_v1, rsp_v2
    );

    modport slave (
        input  req_valid, req_ra, req_rb, req_we, req_wa, req_wd, req_wmask,
        output req_ready, rsp_valid, rsp_id, rsp_v1, rsp_v2
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with a combinational one-hot grant.
//   clk, rst : clock, synchronous active-high reset (prio -> requester 0)
//   req      : request vector
//   en       : arbitration enable; no grant and no priority change when low
//   gnt      : one-hot grant
//   gnt_id   : index of the granted requester (meaningful when |gnt)
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    logic prio;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = prio ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
        gnt_id = gnt[1];
    end

    // Winner drops to lowest priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= 1'b0;
        end else if (en && (req != 2'b00)) begin
            prio <= ~gnt_id;
        end
    end

endmodule

// File: rtl/regfile_ctrl.sv
// Sequencer/arbiter in front of a 2-read/1-write register file.
// After reset (or clr) it sweeps zeros through registers 1..2^M-1, then
// serves two requesters round-robin, one request per cycle, and tags the
// 1-cycle-latency read data with the owning requester. Writes to register 0
// are suppressed.
//   clk, rst        : clock, synchronous active-high reset
//   clr             : restart the clear sweep
//   busy            : high while sweeping
//   bus             : requester interface (slave side)
//   rf_r1/r2/w1     : register file read/write addresses
//   rf_mask/wf/w    : register file write mask, write flag, write data
//   rf_v1/v2        : register file read data (one cycle after address)
module regfile_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int unsigned N = 32,
    parameter int unsigned M = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    output logic         busy,
    regfile_ctrl_if.slave bus,
    output logic [M-1:0] rf_r1,
    output logic [M-1:0] rf_r2,
    output logic [M-1:0] rf_w1,
    output logic [N-1:0] rf_mask,
    output logic         rf_wf,
    output logic [N-1:0] rf_w,
    input  logic [N-1:0] rf_v1,
    input  logic [N-1:0] rf_v2
);

    localparam logic [M-1:0] IDX_LAST  = {M{1'b1}};
    localparam logic [M-1:0] IDX_FIRST = M'(1);

    state_t       state;
    logic [M-1:0] idx;
    logic         rsp_valid_q;
    logic         rsp_id_q;
    logic [1:0]   gnt;
    logic         gnt_id;
    logic [M-1:0] wa_g;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (bus.req_valid),
        .en     (state == ST_RUN),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign busy          = (state == ST_CLEAR);
    assign bus.req_ready = gnt;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_v1    = rf_v1;
    assign bus.rsp_v2    = rf_v2;

    assign wa_g = gnt_id ? bus.req_wa[M +: M] : bus.req_wa[0 +: M];

    always_comb begin
        rf_r1   = '0;
        rf_r2   = '0;
        rf_w1   = '0;
        rf_mask = '0;
        rf_wf   = 1'b0;
        rf_w    = '0;
        unique case (state)
            ST_CLEAR: begin
                rf_wf   = 1'b1;
                rf_w1   = idx;
                rf_mask = '1;
            end
            ST_RUN: begin
                if (gnt != 2'b00) begin
                    rf_r1   = gnt_id ? bus.req_ra[M +: M]    : bus.req_ra[0 +: M];
                    rf_r2   = gnt_id ? bus.req_rb[M +: M]    : bus.req_rb[0 +: M];
                    rf_w1   = wa_g;
                    rf_w    = gnt_id ? bus.req_wd[N +: N]    : bus.req_wd[0 +: N];
                    rf_mask = gnt_id ? bus.req_wmask[N +: N] : bus.req_wmask[0 +: N];
                    // Register 0 is hardwired to zero: address/data still shown.
                    rf_wf   = bus.req_we[gnt_id] && (wa_g != '0);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_CLEAR;
            idx         <= IDX_FIRST;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
        end else begin
            unique case (state)
                ST_CLEAR: begin
                    rsp_valid_q <= 1'b0;
                    if (clr) begin
                        idx <= IDX_FIRST;
                    end else if (idx == IDX_LAST) begin
                        state <= ST_RUN;
                    end else begin
                        idx <= idx + M'(1);
                    end
                end
                ST_RUN: begin
                    // A grant in the same cycle as clr still gets its response.
                    rsp_valid_q <= (gnt != 2'b00);
                    rsp_id_q    <= gnt_id;
                    if (clr) begin
                        state <= ST_CLEAR;
                        idx   <= IDX_FIRST;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_ctrl.sv
module tb_regfile_ctrl;
    import regfile_ctrl_pkg::*;

    localparam int N = 32;
    localparam int M = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic          busy;
    logic [M-1:0]  rf_r1, rf_r2, rf_w1;
    logic [N-1:0]  rf_mask, rf_w, rf_v1, rf_v2;
    logic          rf_wf;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_ctrl_if #(.N(N), .M(M)) bus ();

    regfile_ctrl #(.N(N), .M(M)) dut (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .busy    (busy),
        .bus     (bus),
        .rf_r1   (rf_r1),
        .rf_r2   (rf_r2),
        .rf_w1   (rf_w1),
        .rf_mask (rf_mask),
        .rf_wf   (rf_wf),
        .rf_w    (rf_w),
        .rf_v1   (rf_v1),
        .rf_v2   (rf_v2)
    );

    always #5 clk = ~clk;

    // Register file: registered reads, masked write, register 0 reads as zero.
    logic [N-1:0] rf_mem [4];
    always @(posedge clk) begin
        rf_v1 <= (rf_r1 == 0) ? '0 : rf_mem[rf_r1];
        rf_v2 <= (rf_r2 == 0) ? '0 : rf_mem[rf_r2];
        if (rf_wf) rf_mem[rf_w1] <= (rf_mem[rf_w1] & ~rf_mask) | (rf_w & rf_mask);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_init  = 0;
    bit          m_clear;
    int          m_idx;
    int          m_prio;
    bit          m_rspv;
    int          m_rspid;
    logic [31:0] m_rv1, m_rv2;
    logic [31:0] m_mem [4];

    function automatic int m_grant(input logic [1:0] v, input int p);
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
        if (v == 2'b11) return p;
        return -1;
    endfunction

    always @(posedge clk) begin
        int g;
        int wa;
        logic [31:0] mk;
        if (rst) begin
            m_init = 1; m_clear = 1; m_idx = 1; m_prio = 0; m_rspv = 0; m_rspid = 0;
            m_mem[0] = 0;
        end else if (m_init) begin
            if (m_clear) begin
                m_mem[m_idx] = 0;
                m_rspv = 0;
                if (clr) m_idx = 1;
                else if (m_idx == 3) m_clear = 0;
                else m_idx++;
            end else begin
                g = m_grant(bus.req_valid, m_prio);
                if (g >= 0) begin
                    m_rv1 = m_mem[int'(bus.req_ra[g*2 +: 2])];
                    m_rv2 = m_mem[int'(bus.req_rb[g*2 +: 2])];
                    wa = int'(bus.req_wa[g*2 +: 2]);
                    mk = bus.req_wmask[g*32 +: 32];
                    if (bus.req_we[g] && wa != 0)
                        m_mem[wa] = (m_mem[wa] & ~mk) | (bus.req_wd[g*32 +: 32] & mk);
                    m_prio = 1 - g;
                    m_rspv = 1;
                    m_rspid = g;
                end else begin
                    m_rspv = 0;
                end
                if (clr) begin m_clear = 1; m_idx = 1; end
            end
        end
    end

    // Compare process: every cycle out of reset.
    always @(negedge clk) begin
        int g;
        logic [31:0] e_r1, e_r2, e_w1, e_mask, e_w, e_rdy;
        logic e_wf;
        if (!rst && m_init) begin
            e_r1 = 0; e_r2 = 0; e_w1 = 0; e_mask = 0; e_w = 0; e_wf = 0; e_rdy = 0;
            if (m_clear) begin
                e_wf = 1; e_w1 = m_idx; e_mask = 32'hFFFF_FFFF;
            end else begin
                g = m_grant(bus.req_valid, m_prio);
                if (g >= 0) begin
                    e_rdy  = 32'(1) << g;
                    e_r1   = 32'(bus.req_ra[g*2 +: 2]);
                    e_r2   = 32'(bus.req_rb[g*2 +: 2]);
                    e_w1   = 32'(bus.req_wa[g*2 +: 2]);
                    e_w    = bus.req_wd[g*32 +: 32];
                    e_mask = bus.req_wmask[g*32 +: 32];
                    e_wf   = bus.req_we[g] && (bus.req_wa[g*2 +: 2] != 0);
                end
            end
            chk("busy", 32'(busy), 32'(m_clear));
            chk("req_ready", 32'(bus.req_ready), e_rdy);
            chk("rf_wf", 32'(rf_wf), 32'(e_wf));
            chk("rf_r1", 32'(rf_r1), e_r1);
            chk("rf_r2", 32'(rf_r2), e_r2);
            chk("rf_w1", 32'(rf_w1), e_w1);
            chk("rf_w", rf_w, e_w);
            chk("rf_mask", rf_mask, e_mask);
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_rspv));
            if (m_rspv) begin
                chk("rsp_id", 32'(bus.rsp_id), 32'(m_rspid));
                chk("rsp_v1", bus.rsp_v1, m_rv1);
                chk("rsp_v2", bus.rsp_v2, m_rv2);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req_valid = '0; bus.req_ra = '0; bus.req_rb = '0; bus.req_we = '0;
        bus.req_wa = '0; bus.req_wd = '0; bus.req_wmask = '0;
    endtask

    task automatic drive(input int id, input logic [1:0] ra, input logic [1:0] rb,
                         input logic we, input logic [1:0] wa,
                         input logic [31:0] wd, input logic [31:0] mk);
        bus.req_valid[id]         = 1'b1;
        bus.req_ra[id*2 +: 2]     = ra;
        bus.req_rb[id*2 +: 2]     = rb;
        bus.req_we[id]            = we;
        bus.req_wa[id*2 +: 2]     = wa;
        bus.req_wd[id*32 +: 32]   = wd;
        bus.req_wmask[id*32 +: 32] = mk;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; idle();
        cyc(); cyc();
        rst = 1'b0;

        // Reset sweep: indices 1,2,3 then run.
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk("sweep_busy", 32'(busy), 32'd1);
            chk("sweep_w1", 32'(rf_w1), 32'(i));
            chk("sweep_mask", rf_mask, 32'hFFFF_FFFF);
            chk("sweep_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            cyc();
        end
        @(negedge clk);
        chk("run_busy", 32'(busy), 32'd0);
        drive(0, 2'd0, 2'd0, 1'b1, 2'd2, 32'hDEAD_BEEF, 32'h0000_FFFF);
        @(negedge clk);
        chk("mw_ready", 32'(bus.req_ready), 32'd1);
        cyc();
        idle(); drive(0, 2'd2, 2'd0, 1'b0, 2'd0, 32'd0, 32'd0);
        cyc();
        idle();
        @(negedge clk);
        chk("mw_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("mw_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("mw_rsp_v1", bus.rsp_v1, 32'h0000_BEEF);
        cyc();

        // Bring prio back to 0, then contention.
        drive(1, 2'd1, 2'd1, 1'b0, 2'd0, 32'd0, 32'd0);
        cyc();
        for (int i = 0; i < 4; i++) begin
            drive(0, 2'd2, 2'd1, 1'b0, 2'd0, 32'd0, 32'd0);
            drive(1, 2'd1, 2'd2, 1'b0, 2'd0, 32'd0, 32'd0);
            @(negedge clk);
            chk("cont_ready", 32'(bus.req_ready), (i % 2 == 0) ? 32'd1 : 32'd2);
            if (i > 0) chk("cont_rsp_id", 32'(bus.rsp_id), 32'((i - 1) % 2));
            cyc();
        end
        idle();
        @(negedge clk);
        chk("cont_rsp_id_last", 32'(bus.rsp_id), 32'd1);
        cyc();

        // Register 0 protection.
        drive(1, 2'd0, 2'd0, 1'b1, 2'd0, 32'd5, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("r0_wf", 32'(rf_wf), 32'd0);
        cyc();
        idle(); drive(1, 2'd0, 2'd0, 1'b0, 2'd0, 32'd0, 32'd0);
        @(negedge clk);
        chk("r0_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("r0_rsp_id", 32'(bus.rsp_id), 32'd1);
        cyc();
        idle();
        @(negedge clk);
        chk("r0_rsp_v1", bus.rsp_v1, 32'd0);
        cyc();

        // Same-cycle read-after-write on register 3.
        drive(0, 2'd3, 2'd0, 1'b1, 2'd3, 32'd7, 32'hFFFF_FFFF);
        cyc();
        idle(); drive(0, 2'd3, 2'd0, 1'b0, 2'd0, 32'd0, 32'd0);
        @(negedge clk);
        chk("raw_old", bus.rsp_v1, 32'd0);
        cyc();
        idle();
        @(negedge clk);
        chk("raw_new", bus.rsp_v1, 32'd7);
        cyc();

        // clr alongside a granted read.
        drive(0, 2'd0, 2'd0, 1'b1, 2'd1, 32'hAA, 32'hFFFF_FFFF);
        cyc();
        idle(); drive(0, 2'd1, 2'd0, 1'b0, 2'd0, 32'd0, 32'd0); clr = 1'b1;
        cyc();
        idle(); clr = 1'b0;
        @(negedge clk);
        chk("clr_rsp_v1", bus.rsp_v1, 32'hAA);
        chk("clr_busy", 32'(busy), 32'd1);
        cyc();
        clr = 1'b1;
        @(negedge clk);
        chk("clr_mid_w1", 32'(rf_w1), 32'd2);
        cyc();
        clr = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk("resweep_w1", 32'(rf_w1), 32'(i));
            cyc();
        end
        drive(0, 2'd1, 2'd0, 1'b0, 2'd0, 32'd0, 32'd0);
        cyc();
        idle();
        @(negedge clk);
        chk("clr_reg1_zero", bus.rsp_v1, 32'd0);
        cyc();

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            idle();
            for (int r = 0; r < 2; r++)
                if ($urandom_range(0, 2) != 0)
                    drive(r, 2'($urandom), 2'($urandom), 1'($urandom), 2'($urandom),
                          $urandom, ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom);
            clr = ($urandom_range(0, 39) == 0);
            rst = ($urandom_range(0, 499) == 0);
            cyc();
        end
        rst = 1'b0; clr = 1'b0; idle();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
